// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StAck,
    StWaitIdle
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // Odd parity: the bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer, 4-sample stability filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       fall_q, fall_d;

  // Idle PS/2 lines float high, so everything resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= 2'd0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = 2'd0;
    end else if (cnt_q == 2'd3) begin
      filt_d = sync_q[1];
      cnt_d  = 2'd0;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
    fall_d = filt_q & ~filt_d;
  end

  assign filtered = filt_q;
  assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-collector lines via output enables.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 1200,
  parameter int unsigned TIMEOUT_CYCLES = 150000
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  output logic       BUSY
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_e   state_q, state_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic            data_oe_q, data_oe_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic clk_filt, clk_fall;
  logic data_filt, unused_data_fall;
  logic inhibit_last;
  logic timeout;

  ps2_line_filter u_clk_filter (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .raw      (PS2_CLK_IN),
    .filtered (clk_filt),
    .fall     (clk_fall)
  );

  ps2_line_filter u_data_filter (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .raw      (PS2_DATA_IN),
    .filtered (data_filt),
    .fall     (unused_data_fall)
  );

  assign inhibit_last = (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // The accept cycle counts as cycle 0, so the first busy cycle holds 1.
  always_comb begin
    to_cnt_d = (state_q == StIdle) ? ToW'(1) : to_cnt_q + ToW'(1);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout = (state_q != StIdle) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      inh_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (TX_VALID) begin
          data_d    = TX_DATA;
          parity_d  = odd_parity(TX_DATA);
          inh_cnt_d = '0;
          bit_cnt_d = 4'd0;
          data_oe_d = 1'b0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (inhibit_last) begin
          data_oe_d = 1'b1;
          state_d   = StReq;
        end else begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
        end
      end
      StReq: begin
        if (clk_fall) begin
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StAck: begin
        if (clk_fall) begin
          ack_d   = ~data_filt;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_filt && data_filt) begin
          done_d  = ack_q;
          error_d = ~ack_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A completion in the same cycle as the watchdog wins.
    if (timeout && !(done_d || error_d)) begin
      state_d   = StIdle;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
    end
  end

  assign TX_READY    = (state_q == StIdle);
  assign BUSY        = ~TX_READY;
  assign PS2_CLK_OE  = (state_q == StInhibit);
  // Start bit goes out on the last inhibit cycle, before the clock is released.
  assign PS2_DATA_OE = data_oe_q | ((state_q == StInhibit) && inhibit_last);
  assign TX_DONE     = done_q;
  assign TX_ERROR    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a clocking PS/2 device model on open-collector lines.
module tb_ps2_host_tx;

  localparam int unsigned INH = 100;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO = 2000;
`else
  localparam int unsigned TO = 150000;
`endif
  localparam int H = 40;  // device clock half period in system cycles

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       PS2_CLK_OE, PS2_DATA_OE;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY, TX_DONE, TX_ERROR, BUSY;
  logic       dev_clk_low, dev_data_low;
  wire        ps2_clk_line  = ~(PS2_CLK_OE | dev_clk_low);
  wire        ps2_data_line = ~(PS2_DATA_OE | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .PS2_CLK_IN  (ps2_clk_line),
    .PS2_DATA_IN (ps2_data_line),
    .PS2_CLK_OE  (PS2_CLK_OE),
    .PS2_DATA_OE (PS2_DATA_OE),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .TX_DONE     (TX_DONE),
    .TX_ERROR    (TX_ERROR),
    .BUSY        (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit         is_err;
    bit         chk_frame;
    logic [9:0] frame;
  } exp_t;

  exp_t       sb_q[$];
  int         acc_cyc_q[$];
  int         done_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulse_cyc = 0;
  int         oe_run = 0;
  bit         prev_pulse = 0;
  logic [9:0] dev_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: every completion pulse pops one expectation.
  always @(negedge CLOCK) begin : monitor
    exp_t e;
    if (!RESET_N) begin
      prev_pulse = 0;
    end else if (TX_DONE || TX_ERROR) begin
      check("pulse_width", prev_pulse, 0);
      check("done_error_exclusive", TX_DONE & TX_ERROR, 0);
      check("oe_released_at_pulse", {PS2_CLK_OE, PS2_DATA_OE}, 0);
      check("ready_with_pulse", TX_READY, 1);
      check("pulse_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("outcome_error", TX_ERROR, e.is_err);
        check("outcome_done", TX_DONE, !e.is_err);
        if (e.chk_frame) check("frame", dev_frame, e.frame);
      end
      if (TX_DONE) done_cyc_q.push_back(cyc);
      pulse_cyc  = cyc;
      prev_pulse = 1;
    end else begin
      prev_pulse = 0;
    end
  end

  always @(negedge CLOCK) begin
    if (RESET_N && TX_VALID && TX_READY) acc_cyc_q.push_back(cyc);
  end

  always @(negedge CLOCK) begin
    if (PS2_CLK_OE) begin
      oe_run++;
    end else begin
      if (oe_run != 0) check("inhibit_len", oe_run, INH);
      oe_run = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic dwait(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic push_exp(input bit is_err, input bit chk, input logic [9:0] frame);
    exp_t e;
    e.is_err    = is_err;
    e.chk_frame = chk;
    e.frame     = frame;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLOCK); #1;
    TX_DATA  = b;
    TX_VALID = 1'b1;
    @(negedge CLOCK);
    check("ready_before_send", TX_READY, 1);
    @(posedge CLOCK); #1;
    TX_VALID = 1'b0;
    check("clk_oe_after_accept", PS2_CLK_OE, 1);
    check("busy_after_accept", BUSY, 1);
  endtask

  // Device: wait for request, clock out 10 bits sampled on rising edges, then ACK slot.
  task automatic device_xact(input bit ack, input int rst_bit);
    logic [9:0] frame;
    bit seen;
    seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge CLOCK); #1;
      seen = PS2_CLK_OE;
    end
    seen = 0;
    for (int k = 0; k < INH + 50 && !seen; k++) begin
      @(posedge CLOCK); #1;
      seen = !PS2_CLK_OE && !ps2_data_line;
    end
    check("request_seen", seen, 1);
    if (!seen) return;
    dwait(H);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      dwait(H);
      if (i == rst_bit) begin
        check("data_oe_before_reset", PS2_DATA_OE, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("clk_oe_async_reset", PS2_CLK_OE, 0);
        check("data_oe_async_reset", PS2_DATA_OE, 0);
        dev_clk_low = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      frame[i] = ps2_data_line;
      dwait(H);
    end
    dev_frame = frame;
    if (ack) dev_data_low = 1'b1;
    dwait(H / 2);
    dev_clk_low = 1'b1;
    dwait(H);
    dev_clk_low = 1'b0;
    dwait(H / 2);
    dev_data_low = 1'b0;
    dwait(H);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) @(posedge CLOCK);
    #1;
    check("all_responses_seen", sb_q.size(), 0);
  endtask

  initial begin
    int acc_base, done_base;
    RESET_N      = 1'b0;
    TX_VALID     = 1'b0;
    TX_DATA      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    #23;
    check("reset_clk_oe", PS2_CLK_OE, 0);
    check("reset_data_oe", PS2_DATA_OE, 0);
    check("reset_ready", TX_READY, 1);
    check("reset_busy", BUSY, 0);
    check("reset_pulses", {TX_DONE, TX_ERROR}, 0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    dwait(10);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK.
    push_exp(0, 1, 10'h3ED);
    send(8'hED);
    device_xact(1, -1);
    drain(200);

    // 0x01: parity 0.
    push_exp(0, 1, 10'h201);
    send(8'h01);
    device_xact(1, -1);
    drain(200);

    // 0xFF with no ACK from the device.
    push_exp(1, 1, 10'h3FF);
    send(8'hFF);
    device_xact(0, -1);
    drain(200);
    check("clk_oe_after_nack", PS2_CLK_OE, 0);
    check("data_oe_after_nack", PS2_DATA_OE, 0);

    // Reset during bit 4 of 0x0F (bit 4 is 0, so data OE is asserted there).
    send(8'h0F);
    device_xact(1, 4);
    dwait(3);
    RESET_N = 1'b1;
    dwait(200);
    check("ready_after_reset", TX_READY, 1);
    check("busy_after_reset", BUSY, 0);
    check("oe_after_reset", {PS2_CLK_OE, PS2_DATA_OE}, 0);

    // Back-to-back with TX_VALID held high: 0x55 then 0xAA.
    acc_base  = acc_cyc_q.size();
    done_base = done_cyc_q.size();
    push_exp(0, 1, 10'h355);
    push_exp(0, 1, 10'h3AA);
    @(posedge CLOCK); #1;
    TX_DATA  = 8'h55;
    TX_VALID = 1'b1;
    @(posedge CLOCK); #1;
    TX_DATA = 8'hAA;
    device_xact(1, -1);
    for (int k = 0; k < 300 && acc_cyc_q.size() < acc_base + 2; k++) begin
      @(posedge CLOCK); #1;
    end
    TX_VALID = 1'b0;
    check("second_accept_seen", acc_cyc_q.size(), acc_base + 2);
    device_xact(1, -1);
    drain(200);
    check("accept_count_b2b", acc_cyc_q.size(), acc_base + 2);
    if (acc_cyc_q.size() >= acc_base + 2 && done_cyc_q.size() > done_base)
      check("second_accept_on_done", acc_cyc_q[acc_base + 1], done_cyc_q[done_base]);
    else
      check("b2b_history_present", done_cyc_q.size(), done_base + 2);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog fires TO cycles after acceptance.
    acc_base = acc_cyc_q.size();
    push_exp(1, 0, 10'h000);
    send(8'h12);
    drain(TO + 200);
    check("timeout_accept_seen", acc_cyc_q.size(), acc_base + 1);
    if (acc_cyc_q.size() > acc_base)
      check("timeout_latency", pulse_cyc - acc_cyc_q[acc_base], TO);
    check("ready_after_timeout", TX_READY, 1);
    check("oe_after_timeout", {PS2_CLK_OE, PS2_DATA_OE}, 0);
`endif

    dwait(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
